// File: rtl/cpu_clk_switch_m_pkg.sv
// Shared encodings and defaults for the level1b CPU clock switch.
package cpu_clk_switch_m_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CLK_DIV_W       = 2;

  // cpuclk_div_sel encodings for the hs divider
  typedef enum logic [CLK_DIV_W-1:0] {
    CLKDIV_1 = 2'b00,
    CLKDIV_2 = 2'b01,
    CLKDIV_3 = 2'b10,
    CLKDIV_4 = 2'b11
  } clkdiv_e;

endpackage

// File: rtl/cpu_clk_switch_m_sync.sv
// Negedge-clocked multi-flop synchroniser with async active-low reset.
module clk_sync_m #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_clk_switch_m.sv
// Glitch-free ls/hs CPU clock switch with /1../4 hs divider; drives cpu_phi2.
module cpu_clk_switch_m
  import cpu_clk_switch_m_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DIV_W       = CLK_DIV_W
) (
  input  logic             hsclk_in,
  input  logic             lsclk_in,
  input  logic             resetb,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] cpuclk_div_sel,
  output logic             hsclk_selected,
  output logic             lsclk_selected,
  output logic             clkout
);

  localparam logic [DIV_W-1:0] DIV_BYPASS = DIV_W'(CLKDIV_1);

  logic             ls_en, hs_en;
  logic             hs_en_sync_ls, ls_en_sync_hs;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [DIV_W-1:0] div_cnt_nxt, div_hi_start;
  logic             hs_div_q, hs_div_nxt;
  logic             div_wrap, div_load, div_ok;
  logic             hs_clk_w, ls_gate, hs_gate;

  clk_sync_m #(.STAGES(SYNC_STAGES)) u_sync_hs2ls (
    .clk    (lsclk_in),
    .resetb (resetb),
    .d      (hs_en),
    .q      (hs_en_sync_ls)
  );

  clk_sync_m #(.STAGES(SYNC_STAGES)) u_sync_ls2hs (
    .clk    (hsclk_in),
    .resetb (resetb),
    .d      (ls_en),
    .q      (ls_en_sync_hs)
  );

  // ls enable moves only while lsclk is low
  always_ff @(negedge lsclk_in or negedge resetb) begin
    if (!resetb) ls_en <= 1'b1;
    else         ls_en <= !hsclk_sel && !hs_en_sync_ls;
  end

  // Divider next state. div_q reloads only at a wrap (or while hs is idle).
  always_comb begin
    div_wrap     = (div_cnt == div_q);
    div_load     = div_wrap || !hs_en;
    div_hi_start = DIV_W'(({1'b0, div_q} + (DIV_W+1)'(2)) >> 1);
    div_cnt_nxt  = div_cnt + 1'b1;
    hs_div_nxt   = 1'b0;
    if (div_load) begin
      // Leaving /1 at a posedge: enter on the last (high) count so the
      // hsclk high phase that just started continues instead of being cut.
      if (hs_en && (div_q == DIV_BYPASS) && (cpuclk_div_sel != DIV_BYPASS)) begin
        div_cnt_nxt = cpuclk_div_sel;
        hs_div_nxt  = 1'b1;
      end else begin
        div_cnt_nxt = '0;
      end
    end else begin
      hs_div_nxt = (div_cnt_nxt >= div_hi_start);
    end
  end

  always_ff @(posedge hsclk_in or negedge resetb) begin
    if (!resetb) begin
      div_q    <= '0;
      div_cnt  <= '0;
      hs_div_q <= 1'b0;
    end else begin
      if (div_load) div_q <= cpuclk_div_sel;
      div_cnt  <= div_cnt_nxt;
      hs_div_q <= hs_div_nxt;
    end
  end

  // Count 0 is always a low phase of the divided clock, so hs_en may move there.
  assign div_ok = (div_q == DIV_BYPASS) || (div_cnt == '0);

  always_ff @(negedge hsclk_in or negedge resetb) begin
    if (!resetb)     hs_en <= 1'b0;
    else if (div_ok) hs_en <= hsclk_sel && !ls_en_sync_hs;
  end

  assign hs_clk_w = (div_q == DIV_BYPASS) ? hsclk_in : hs_div_q;

  // Gating terms: keep as discrete AND/OR cells in implementation so the
  // enable-before-clock ordering that makes the switch glitch-free survives.
  assign ls_gate = ls_en & lsclk_in;
  assign hs_gate = hs_en & hs_clk_w;
  assign clkout  = ls_gate | hs_gate;

  assign hsclk_selected = hs_en;
  assign lsclk_selected = ls_en;

endmodule

// File: tb/tb_cpu_clk_switch_m.sv
// Scoreboard bench for cpu_clk_switch_m: stimulus queues expectations, monitor checks clkout.
`timescale 1ns/1ps
module tb_cpu_clk_switch_m;

  logic       hsclk_in = 1'b0;
  logic       lsclk_in = 1'b0;
  logic       resetb = 1'b1;
  logic       hsclk_sel = 1'b0;
  logic [1:0] cpuclk_div_sel = 2'b00;
  logic       hsclk_selected, lsclk_selected, clkout;

  cpu_clk_switch_m #(.SYNC_STAGES(2), .DIV_W(2)) dut (
    .hsclk_in       (hsclk_in),
    .lsclk_in       (lsclk_in),
    .resetb         (resetb),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .clkout         (clkout)
  );

  initial begin #7; forever #31.25 hsclk_in = ~hsclk_in; end
  initial forever #250 lsclk_in = ~lsclk_in;

  typedef enum {K_CYCLE, K_STATUS, K_LOWMIN} kind_e;
  typedef struct {
    string   name;
    kind_e   kind;
    bit      hs;
    bit      ls;
    bit      chk_clk;
    realtime hi;
    realtime lo;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, passed = 0, issued = 0, consumed = 0;

  task automatic chk(input string name, input bit ok, input string act, input string req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  function automatic realtime rabs(input realtime x);
    return (x < 0) ? -x : x;
  endfunction

  // clkout edge recorder
  int rise_n = 0, fall_n = 0;
  realtime t_rise, t_fall;
  always @(posedge clkout) begin rise_n++; t_rise = $realtime; end
  always @(negedge clkout) begin fall_n++; t_fall = $realtime; end

  task automatic wait_edge(input bit rising, output bit ok);
    int n0 = rising ? rise_n : fall_n;
    int t = 0;
    while (((rising ? rise_n : fall_n) == n0) && t < 20000) begin #1; t++; end
    ok = ((rising ? rise_n : fall_n) != n0);
  endtask

  // Monitor: pops expectations and compares against what the DUT presents
  initial begin : monitor
    exp_t e;
    bit ok1, ok2, ok3;
    realtime r1, f1, r2;
    forever begin
      while (exp_q.size() == 0) #1;
      e = exp_q.pop_front();
      case (e.kind)
        K_STATUS: begin
          chk({e.name, ".hs_sel"}, hsclk_selected === e.hs,
              $sformatf("%b", hsclk_selected), $sformatf("%b", e.hs));
          chk({e.name, ".ls_sel"}, lsclk_selected === e.ls,
              $sformatf("%b", lsclk_selected), $sformatf("%b", e.ls));
          if (e.chk_clk)
            chk({e.name, ".clk_eq_ls"}, clkout === lsclk_in,
                $sformatf("%b", clkout), $sformatf("%b", lsclk_in));
        end
        K_CYCLE: begin
          wait_edge(1'b1, ok1); r1 = t_rise;
          wait_edge(1'b0, ok2); f1 = t_fall;
          wait_edge(1'b1, ok3); r2 = t_rise;
          #2;
          if (!(ok1 && ok2 && ok3)) begin
            chk({e.name, ".edges"}, 1'b0, "no clkout cycle", "clkout cycle");
          end else begin
            chk({e.name, ".hi"}, rabs((f1 - r1) - e.hi) < 0.5,
                $sformatf("%0.2fns", f1 - r1), $sformatf("%0.2fns", e.hi));
            chk({e.name, ".lo"}, rabs((r2 - f1) - e.lo) < 0.5,
                $sformatf("%0.2fns", r2 - f1), $sformatf("%0.2fns", e.lo));
          end
          chk({e.name, ".hs_sel"}, hsclk_selected === e.hs,
              $sformatf("%b", hsclk_selected), $sformatf("%b", e.hs));
          chk({e.name, ".ls_sel"}, lsclk_selected === e.ls,
              $sformatf("%b", lsclk_selected), $sformatf("%b", e.ls));
        end
        K_LOWMIN: begin
          wait_edge(1'b1, ok1);
          if (!ok1) chk({e.name, ".edges"}, 1'b0, "no clkout rise", "clkout rise");
          else chk({e.name, ".low_gap"}, (t_rise - t_fall) >= e.lo,
                   $sformatf("%0.2fns", t_rise - t_fall), $sformatf(">=%0.2fns", e.lo));
        end
        default: ;
      endcase
      consumed++;
    end
  end

  // Continuous checks: minimum phase width outside reset, exclusive enables
  realtime t_edge;
  bit      edge_seen = 1'b0;
  logic    last_clk;
  always @(clkout or resetb) begin
    if (resetb !== 1'b1) edge_seen = 1'b0;
    else if (clkout !== last_clk) begin
      if (edge_seen)
        chk("min_phase", ($realtime - t_edge) >= 31.0,
            $sformatf("%0.2fns at %0t", $realtime - t_edge, $time), ">=31ns");
      t_edge = $realtime;
      edge_seen = 1'b1;
    end
    last_clk = clkout;
  end

  always @(hsclk_selected or lsclk_selected)
    if (resetb === 1'b1)
      chk("excl_sel", !(hsclk_selected === 1'b1 && lsclk_selected === 1'b1),
          $sformatf("hs=%b ls=%b", hsclk_selected, lsclk_selected), "not both 1");

  // Stimulus-side helpers: push the expectation, then wait (bounded) for it to be consumed
  task automatic issue(input exp_t e);
    int t = 0;
    exp_q.push_back(e);
    issued++;
    while (consumed != issued && t < 40000) begin #1; t++; end
    if (consumed != issued) chk({e.name, ".sb_timeout"}, 1'b0, "not consumed", "consumed");
  endtask

  task automatic exp_cycle(input string n, input bit hs, input bit ls, input realtime hi, input realtime lo);
    exp_t e;
    e.name = n; e.kind = K_CYCLE; e.hs = hs; e.ls = ls; e.chk_clk = 1'b0; e.hi = hi; e.lo = lo;
    issue(e);
  endtask

  task automatic exp_status(input string n, input bit hs, input bit ls, input bit cc);
    exp_t e;
    e.name = n; e.kind = K_STATUS; e.hs = hs; e.ls = ls; e.chk_clk = cc; e.hi = 0; e.lo = 0;
    issue(e);
  endtask

  task automatic exp_lowmin(input string n, input realtime lo);
    exp_t e;
    e.name = n; e.kind = K_LOWMIN; e.hs = 1'b0; e.ls = 1'b0; e.chk_clk = 1'b0; e.hi = 0; e.lo = lo;
    issue(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded 200us");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1 resetb = 1'b0;
    #2;
    exp_status("rst", 1'b0, 1'b1, 1'b1);
    exp_cycle("rst_ls", 1'b0, 1'b1, 250.0, 250.0);
    resetb = 1'b1;
    exp_cycle("ls_run", 1'b0, 1'b1, 250.0, 250.0);

    // ls -> hs /1
    @(negedge lsclk_in); #20;
    hsclk_sel = 1'b1;
    #1000;
    exp_status("hs1_sel", 1'b1, 1'b0, 1'b0);
    exp_cycle("hs_div1", 1'b1, 1'b0, 31.25, 31.25);

    // /1 -> /3, then /3 -> /4 requested mid high phase
    cpuclk_div_sel = 2'b10;
    #600;
    exp_cycle("hs_div3", 1'b1, 1'b0, 62.5, 125.0);
    @(posedge clkout); #10;
    cpuclk_div_sel = 2'b11;
    #600;
    exp_cycle("hs_div4", 1'b1, 1'b0, 125.0, 125.0);

    // hs /4 -> ls
    @(negedge clkout); #5;
    hsclk_sel = 1'b0;
    exp_lowmin("hs2ls_gap", 1000.0);
    exp_status("ls_back_sel", 1'b0, 1'b1, 1'b0);
    exp_cycle("ls_back", 1'b0, 1'b1, 250.0, 250.0);

    // short select pulse across one lsclk negedge
    @(negedge lsclk_in); #20;
    hsclk_sel = 1'b1;
    @(negedge lsclk_in); #20;
    hsclk_sel = 1'b0;
    exp_lowmin("pulse_gap", 500.0);
    exp_cycle("pulse_ls", 1'b0, 1'b1, 250.0, 250.0);

    // back to hs /3, then reset mid high phase
    cpuclk_div_sel = 2'b10;
    @(negedge lsclk_in); #20;
    hsclk_sel = 1'b1;
    #1500;
    exp_cycle("hs3_again", 1'b1, 1'b0, 62.5, 125.0);
    @(posedge clkout); #10;
    resetb = 1'b0;
    #1;
    exp_status("rst_mid", 1'b0, 1'b1, 1'b1);
    exp_cycle("rst_mid_ls", 1'b0, 1'b1, 250.0, 250.0);
    hsclk_sel = 1'b0;
    @(negedge lsclk_in); #20;
    resetb = 1'b1;
    exp_cycle("post_rst_ls", 1'b0, 1'b1, 250.0, 250.0);
    exp_status("post_rst_sel", 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
